// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU, result {rem, quo}
//   clk, rst (async active-low), start_i, signed_div_i, opdata1_i (dividend),
//   opdata2_i (divisor), annul_i (flush) -> result_o {rem, quo}, ready_o
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_e;
  state_e              state_q;
  logic [2*DATA_W-1:0] rq_q, rq_d, fix_d;
  logic [DATA_W-1:0]   dvd_q, dvs_q, abs1_d, abs2_d, rem, quo;
  logic [DATA_W:0]     rem_sh, diff;
  logic [CW-1:0]       cnt_q;
  logic                sd_q, s1_q, s2_q;
  // rem < divisor always fits DATA_W bits, so a set top bit of rem_sh forces a non-negative trial
  always_comb begin
    rem_sh = {rq_q[2*DATA_W-1:DATA_W], dvd_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    rq_d   = {diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0], rq_q[DATA_W-2:0], ~diff[DATA_W]};
    rem    = rq_q[2*DATA_W-1:DATA_W];
    quo    = rq_q[DATA_W-1:0];
    fix_d  = {(sd_q & s1_q) ? -rem : rem, (sd_q & (s1_q ^ s2_q)) ? -quo : quo};
    abs1_d = (signed_div_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs2_d = (signed_div_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      result_o <= '0;
      ready_o  <= 1'b0;
      cnt_q    <= '0;
      rq_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sd_q     <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            // divide-by-zero clears the datapath so the shared sign fix yields 0
            state_q <= (opdata2_i == '0) ? DIVZERO : BUSY;
            sd_q    <= signed_div_i & (opdata2_i != '0);
            s1_q    <= opdata1_i[DATA_W-1];
            s2_q    <= opdata2_i[DATA_W-1];
            dvd_q   <= abs1_d;
            dvs_q   <= abs2_d;
            rq_q    <= '0;
            cnt_q   <= '0;
          end
        end
        DIVZERO: state_q <= annul_i ? IDLE : DONE;
        BUSY: begin
          if (annul_i) state_q <= IDLE;
          else begin
            rq_q    <= rq_d;
            dvd_q   <= {dvd_q[DATA_W-2:0], 1'b0};
            cnt_q   <= cnt_q + 1'b1;
            state_q <= (cnt_q == CW'(DATA_W - 1)) ? DONE : BUSY;
          end
        end
        default: begin
          // latched operands are stable here, so result_o stays constant while held
          if (annul_i || !start_i) begin
            state_q  <= IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            ready_o  <= 1'b1;
            result_o <= fix_d;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sdiv = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  int          tests = 0;
  int          fails = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .signed_div_i(sdiv),
    .opdata1_i(opa), .opdata2_i(opb), .annul_i(annul),
    .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sd,
                       output int lat, output logic [63:0] res);
    @(negedge clk);
    opa = a; opb = b; sdiv = sd; start = 1'b1;
    lat = -1;
    res = '0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        opa = ~a;
        opb = b ^ 32'h5;
      end
      if (ready) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  task automatic drop_start;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ready, result} !== 65'd0) begin
      fails++;
      $display("FAIL reset: got ready=%b result=%h want 0/0", ready, result);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned;
    int lat;
    logic [63:0] r;
    do_op(32'd7, 32'd2, 1'b0, lat, r);
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL divu_7_2_latency: got %0d want 33", lat); end
    tests++;
    if (r !== 64'h00000001_00000003) begin fails++; $display("FAIL divu_7_2: got %h want 0000000100000003", r); end
    @(posedge clk); #1;
    tests++;
    if ({ready, result} !== {1'b1, 64'h00000001_00000003}) begin
      fails++; $display("FAIL divu_hold: got ready=%b result=%h want 1/0000000100000003", ready, result);
    end
    drop_start;
    tests++;
    if ({ready, result} !== 65'd0) begin fails++; $display("FAIL divu_release: got ready=%b result=%h want 0/0", ready, result); end
    do_op(32'hFFFFFFF9, 32'd2, 1'b0, lat, r);
    tests++;
    if (r !== 64'h00000001_7FFFFFFC) begin fails++; $display("FAIL divu_big: got %h want 000000017ffffffc", r); end
    drop_start;
  endtask

  task automatic test_signed;
    int lat;
    logic [63:0] r;
    do_op(32'hFFFFFFF9, 32'd2, 1'b1, lat, r);
    tests++;
    if (r !== 64'hFFFFFFFF_FFFFFFFD) begin fails++; $display("FAIL div_m7_2: got %h want fffffffffffffffd", r); end
    drop_start;
    do_op(32'd7, 32'hFFFFFFFE, 1'b1, lat, r);
    tests++;
    if (r !== 64'h00000001_FFFFFFFD) begin fails++; $display("FAIL div_7_m2: got %h want 00000001fffffffd", r); end
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL div_latency: got %0d want 33", lat); end
    drop_start;
  endtask

  task automatic test_boundary;
    int lat;
    logic [63:0] r;
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, r);
    tests++;
    if (r !== 64'h00000000_80000000) begin fails++; $display("FAIL div_overflow: got %h want 0000000080000000", r); end
    drop_start;
    do_op(32'hFFFFFFFF, 32'd1, 1'b0, lat, r);
    tests++;
    if (r !== 64'h00000000_FFFFFFFF) begin fails++; $display("FAIL divu_max_1: got %h want 00000000ffffffff", r); end
    drop_start;
  endtask

  task automatic test_divzero;
    int lat;
    logic [63:0] r;
    do_op(32'd55, 32'd0, 1'b1, lat, r);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL divzero_latency: got %0d want 2", lat); end
    tests++;
    if (r !== 64'd0) begin fails++; $display("FAIL divzero_result: got %h want 0", r); end
    drop_start;
    do_op(32'd100, 32'd10, 1'b0, lat, r);
    tests++;
    if (r !== 64'h00000000_0000000A) begin fails++; $display("FAIL back_to_back: got %h want 000000000000000a", r); end
    drop_start;
  endtask

  task automatic test_annul;
    int lat;
    int seen;
    logic [63:0] r;
    @(negedge clk);
    opa = 32'd100; opb = 32'd3; sdiv = 1'b0; start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL annul_no_ready: got %0d ready cycles want 0", seen); end
    do_op(32'd9, 32'd4, 1'b0, lat, r);
    tests++;
    if (r !== 64'h00000001_00000002 || lat !== 33) begin
      fails++; $display("FAIL after_annul: got %h lat %0d want 0000000100000002 lat 33", r, lat);
    end
    drop_start;
  endtask

  task automatic test_async_reset;
    int lat;
    logic [63:0] r;
    @(negedge clk);
    opa = 32'd100; opb = 32'd3; sdiv = 1'b0; start = 1'b1;
    repeat (12) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({ready, result} !== 65'd0) begin fails++; $display("FAIL reset_busy: got ready=%b result=%h want 0/0", ready, result); end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    do_op(32'd15, 32'd4, 1'b0, lat, r);
    tests++;
    if (r !== 64'h00000003_00000003 || lat !== 33) begin
      fails++; $display("FAIL after_reset: got %h lat %0d want 0000000300000003 lat 33", r, lat);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({ready, result} !== 65'd0) begin fails++; $display("FAIL reset_done: got ready=%b result=%h want 0/0", ready, result); end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_boundary;
    test_divzero;
    test_annul;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
